// File: rtl/note_seq_pkg.sv
// note_seq_pkg: FSM encodings, default draw geometry/colours and clog2
// shared by the note sequencer engine and its cell placement helper.
package note_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_REC_DRAW  = 3'd1;
    localparam state_t ST_PLAY_READ = 3'd2;
    localparam state_t ST_PLAY_DRAW = 3'd3;
    localparam state_t ST_PLAY_HOLD = 3'd4;

    localparam int DEF_MARGIN = 4;
    localparam int DEF_CELL_W = 36;
    localparam int DEF_CELL_H = 12;

    localparam logic [2:0] DEF_REC_COLOUR  = 3'b100;
    localparam logic [2:0] DEF_PLAY_COLOUR = 3'b110;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/note_seq_if.sv
// note_seq_if: req/ack draw bus from the note sequencer to the VGA drawer.
// master drives the cell request, slave returns the acknowledge.
interface note_seq_if;

    logic       draw_req;
    logic       draw_ack;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;

    modport master (
        output draw_req,
        output x_out,
        output y_out,
        output colour,
        input  draw_ack
    );

    modport slave (
        input  draw_req,
        input  x_out,
        input  y_out,
        input  colour,
        output draw_ack
    );

endinterface

// File: rtl/note_seq_cell_xy.sv
// note_seq_cell_xy: combinational slot index to grid cell top-left (x,y).
// Arithmetic is done IW+8 bits wide and truncated to the 8/7-bit screen.
module note_seq_cell_xy #(
    parameter int IW     = 4,
    parameter int COLS   = 4,
    parameter int MARGIN = 4,
    parameter int CELL_W = 36,
    parameter int CELL_H = 12
) (
    input  logic [IW-1:0] i_slot,
    output logic [7:0]    o_x,
    output logic [6:0]    o_y
);

    localparam int XW = IW + 8;

    logic [XW-1:0] w_slot;
    logic [XW-1:0] w_col;
    logic [XW-1:0] w_row;

    assign w_slot = XW'(i_slot);
    assign w_col  = w_slot % XW'(COLS);
    assign w_row  = w_slot / XW'(COLS);

    assign o_x = 8'(XW'(MARGIN) + w_col * XW'(CELL_W + MARGIN));
    assign o_y = 7'(XW'(MARGIN) + w_row * XW'(CELL_H + MARGIN));

endmodule

// File: rtl/note_seq_engine.sv
// note_seq_engine: note store with record/playback and req/ack cell drawing.
// Define NOTE_SEQ_LOOP_PLAY_EN to make playback wrap until play_stop.
module note_seq_engine
    import note_seq_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         NOTE_W      = 4,
    parameter int         OCT_W       = 2,
    parameter int         COLS        = 4,
    parameter int         MARGIN      = DEF_MARGIN,
    parameter int         CELL_W      = DEF_CELL_W,
    parameter int         CELL_H      = DEF_CELL_H,
    parameter logic [2:0] REC_COLOUR  = DEF_REC_COLOUR,
    parameter logic [2:0] PLAY_COLOUR = DEF_PLAY_COLOUR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NOTE_W-1:0]       note_data,
    input  logic [OCT_W-1:0]        octave_data,
    input  logic                    rec_valid,
    output logic                    rec_ready,
    input  logic                    clear,
    input  logic                    play_start,
    input  logic                    play_stop,
    input  logic                    next_note_en,
    output logic [NOTE_W-1:0]       note_out,
    output logic [OCT_W-1:0]        octave_out,
    output logic                    note_valid,
    output logic [clog2(DEPTH)-1:0] play_idx,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    busy,
    output logic                    done,
    note_seq_if.master              draw
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = OCT_W + NOTE_W;

    state_t            r_state;
    logic [AW-1:0]     r_play_idx;
    logic [AW:0]       r_count;
    logic [NOTE_W-1:0] r_note;
    logic [OCT_W-1:0]  r_oct;
    logic              r_note_valid;
    logic              r_done;
    logic              r_draw_req;
    logic              r_stop_pend;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic [2:0]        r_colour;
    logic [DW-1:0]     r_mem [DEPTH];

    logic              w_idle;
    logic              w_full;
    logic              w_rec_acc;
    logic              w_last;
    logic [AW-1:0]     w_slot;
    logic [7:0]        w_cx;
    logic [6:0]        w_cy;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_full    = (r_count == CW'(DEPTH));
    assign rec_ready = w_idle && !w_full && !play_start && !clear;
    assign w_rec_acc = rec_ready && rec_valid;
    assign w_last    = (CW'(r_play_idx) + CW'(1)) >= r_count;

    // Idle draws target the next free slot; playback draws the playing slot.
    assign w_slot = w_idle ? r_count[AW-1:0] : r_play_idx;

    note_seq_cell_xy #(
        .IW     (AW),
        .COLS   (COLS),
        .MARGIN (MARGIN),
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_cell_xy (
        .i_slot (w_slot),
        .o_x    (w_cx),
        .o_y    (w_cy)
    );

    always_ff @(posedge clk) begin
        if (w_rec_acc) r_mem[r_count[AW-1:0]] <= {octave_data, note_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_play_idx   <= '0;
            r_count      <= '0;
            r_note       <= '0;
            r_oct        <= '0;
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
            r_draw_req   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (play_start) begin
                        if (r_count != '0) begin
                            r_play_idx <= '0;
                            r_state    <= ST_PLAY_READ;
                        end
                    end else if (clear) begin
                        r_count <= '0;
                    end else if (w_rec_acc) begin
                        r_count    <= r_count + CW'(1);
                        r_draw_req <= 1'b1;
                        r_x        <= w_cx;
                        r_y        <= w_cy;
                        r_colour   <= REC_COLOUR;
                        r_state    <= ST_REC_DRAW;
                    end
                end
                ST_REC_DRAW: begin
                    if (draw.draw_ack) begin
                        r_draw_req <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_PLAY_READ: begin
                    if (play_stop) begin
                        r_note_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        {r_oct, r_note} <= r_mem[r_play_idx];
                        r_note_valid    <= 1'b1;
                        r_draw_req      <= 1'b1;
                        r_x             <= w_cx;
                        r_y             <= w_cy;
                        r_colour        <= PLAY_COLOUR;
                        r_state         <= ST_PLAY_DRAW;
                    end
                end
                ST_PLAY_DRAW: begin
                    // A stop here waits for the ack so the request is never withdrawn.
                    if (play_stop) r_stop_pend <= 1'b1;
                    if (draw.draw_ack) begin
                        r_draw_req  <= 1'b0;
                        r_stop_pend <= 1'b0;
                        if (r_stop_pend || play_stop) begin
                            r_note_valid <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_PLAY_HOLD;
                        end
                    end
                end
                ST_PLAY_HOLD: begin
                    if (play_stop) begin
                        r_note_valid <= 1'b0;
                        r_play_idx   <= '0;
                        r_state      <= ST_IDLE;
                    end else if (next_note_en) begin
                        if (!w_last) begin
                            r_play_idx <= r_play_idx + AW'(1);
                            r_state    <= ST_PLAY_READ;
                        end else begin
                            r_done     <= 1'b1;
                            r_play_idx <= '0;
`ifdef NOTE_SEQ_LOOP_PLAY_EN
                            r_state    <= ST_PLAY_READ;
`else
                            r_note_valid <= 1'b0;
                            r_state      <= ST_IDLE;
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign note_out   = r_note;
    assign octave_out = r_oct;
    assign note_valid = r_note_valid;
    assign play_idx   = r_play_idx;
    assign count      = r_count;
    assign full       = w_full;
    assign done       = r_done;
    assign busy       = (r_state == ST_PLAY_READ) ||
                        (r_state == ST_PLAY_DRAW) ||
                        (r_state == ST_PLAY_HOLD);

    assign draw.draw_req = r_draw_req;
    assign draw.x_out    = r_x;
    assign draw.y_out    = r_y;
    assign draw.colour   = r_colour;

endmodule

// File: tb/tb_note_seq_engine.sv
// tb_note_seq_engine: scoreboard bench for note_seq_engine (default geometry).
// Expected draws/notes are queued at stimulus time and popped per draw_req.
module tb_note_seq_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] note_data = '0;
    logic [1:0] octave_data = '0;
    logic       rec_valid = 1'b0;
    logic       clear = 1'b0;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic       next_note_en = 1'b0;
    logic       rec_ready;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic       note_valid;
    logic [3:0] play_idx;
    logic [4:0] count;
    logic       full;
    logic       busy;
    logic       done;

    note_seq_if u_if ();

    note_seq_engine u_dut (
        .clk          (clk),
        .reset        (reset),
        .note_data    (note_data),
        .octave_data  (octave_data),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .clear        (clear),
        .play_start   (play_start),
        .play_stop    (play_stop),
        .next_note_en (next_note_en),
        .note_out     (note_out),
        .octave_out   (octave_out),
        .note_valid   (note_valid),
        .play_idx     (play_idx),
        .count        (count),
        .full         (full),
        .busy         (busy),
        .done         (done),
        .draw         (u_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } draw_t;

    typedef struct packed {
        logic [3:0] n;
        logic [1:0] o;
        logic [3:0] idx;
    } note_t;

    draw_t      q_draw [$];
    note_t      q_note [$];
    logic [5:0] m_mem [16];
    int         m_count = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic draw_t mk_draw(input int i, input logic [2:0] c);
        draw_t d;
        d.x = 8'(4 + (i % 4) * 40);
        d.y = 7'(4 + (i / 4) * 16);
        d.c = c;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic serve(input int dly, input bit tick);
        draw_t d;
        note_t e;
        for (int k = 0; k < 20 && !u_if.draw_req; k++) @(negedge clk);
        if (!u_if.draw_req) begin
            chk("draw_timeout", 32'(u_if.draw_req), 1);
            return;
        end
        if (q_draw.size() == 0) begin
            chk("draw_unexpected", 32'(u_if.draw_req), 0);
            return;
        end
        d = q_draw.pop_front();
        chk("draw_x", 32'(u_if.x_out), 32'(d.x));
        chk("draw_y", 32'(u_if.y_out), 32'(d.y));
        chk("draw_colour", 32'(u_if.colour), 32'(d.c));
        if (d.c == 3'b110 && q_note.size() > 0) begin
            e = q_note.pop_front();
            chk("note_out", 32'(note_out), 32'(e.n));
            chk("octave_out", 32'(octave_out), 32'(e.o));
            chk("play_idx", 32'(play_idx), 32'(e.idx));
            chk("note_valid", 32'(note_valid), 1);
        end
        next_note_en = tick;
        repeat (dly) begin
            @(negedge clk);
            chk("req_hold", 32'(u_if.draw_req), 1);
            chk("x_hold", 32'(u_if.x_out), 32'(d.x));
        end
        next_note_en = 1'b0;
        u_if.draw_ack = 1'b1;
        @(negedge clk);
        u_if.draw_ack = 1'b0;
        chk("req_drop", 32'(u_if.draw_req), 0);
    endtask

    task automatic rec(input logic [3:0] n, input logic [1:0] o,
                       input bit do_serve);
        bit acc;
        @(negedge clk);
        acc = (m_count < 16);
        if (acc) begin
            chk("rec_ready", 32'(rec_ready), 1);
            q_draw.push_back(mk_draw(m_count, 3'b100));
            m_mem[m_count] = {o, n};
            m_count++;
        end else begin
            chk("rec_ready_full", 32'(rec_ready), 0);
        end
        rec_valid   = 1'b1;
        note_data   = n;
        octave_data = o;
        @(negedge clk);
        rec_valid = 1'b0;
        if (acc) begin
            if (do_serve) serve(1, 1'b0);
        end else begin
            chk("drop_req", 32'(u_if.draw_req), 0);
            chk("drop_count", 32'(count), 16);
        end
    endtask

    task automatic tick();
        next_note_en = 1'b1;
        @(negedge clk);
        next_note_en = 1'b0;
    endtask

    task automatic play_all(input int n, input bit extra);
        note_t e;
        for (int i = 0; i < n; i++) begin
            e.n   = m_mem[i][3:0];
            e.o   = m_mem[i][5:4];
            e.idx = 4'(i);
            q_note.push_back(e);
            q_draw.push_back(mk_draw(i, 3'b110));
        end
        @(negedge clk);
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        chk("play_busy", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            serve(1, extra && i == 0);
            tick();
            if (i < n - 1) begin
                chk("done_early", 32'(done), 0);
            end else begin
                chk("done_pulse", 32'(done), 1);
                chk("end_busy", 32'(busy), 0);
                chk("end_note_valid", 32'(note_valid), 0);
                chk("end_play_idx", 32'(play_idx), 0);
                @(negedge clk);
                chk("done_once", 32'(done), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog n_checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        note_t e;
        u_if.draw_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_req", 32'(u_if.draw_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_note_valid", 32'(note_valid), 0);
        chk("rst_colour", 32'(u_if.colour), 0);
        reset = 1'b1;
        @(negedge clk);

        rec(4'd7, 2'd2, 1'b0);
        chk("mid_req", 32'(u_if.draw_req), 1);
        q_draw.delete();
        m_count = 0;
        #2 reset = 1'b0;
        #1;
        chk("async_req", 32'(u_if.draw_req), 0);
        chk("async_count", 32'(count), 0);
        chk("async_x", 32'(u_if.x_out), 0);
        chk("async_y", 32'(u_if.y_out), 0);
        chk("async_colour", 32'(u_if.colour), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_ready", 32'(rec_ready), 1);

        rec(4'd5, 2'd1, 1'b1);
        rec(4'd2, 2'd0, 1'b1);
        rec(4'd11, 2'd3, 1'b1);
        chk("count3", 32'(count), 3);

        play_all(3, 1'b1);

        e = '{n: 4'd5, o: 2'd1, idx: 4'd0};
        q_note.push_back(e);
        q_draw.push_back(mk_draw(0, 3'b110));
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        @(negedge clk);
        play_stop = 1'b1;
        @(negedge clk);
        play_stop = 1'b0;
        chk("stop_req_held", 32'(u_if.draw_req), 1);
        chk("stop_busy_held", 32'(busy), 1);
        serve(1, 1'b0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_note_valid", 32'(note_valid), 0);
        chk("stop_no_done", 32'(done), 0);

        @(negedge clk);
        play_start = 1'b1;
        clear      = 1'b1;
        rec_valid  = 1'b1;
        note_data  = 4'd9;
        #1 chk("prio_ready", 32'(rec_ready), 0);
        @(negedge clk);
        play_start = 1'b0;
        clear      = 1'b0;
        rec_valid  = 1'b0;
        chk("prio_busy", 32'(busy), 1);
        chk("prio_count", 32'(count), 3);
        play_stop = 1'b1;
        @(negedge clk);
        play_stop = 1'b0;
        chk("read_stop_busy", 32'(busy), 0);
        chk("read_stop_req", 32'(u_if.draw_req), 0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        chk("clear_count", 32'(count), 0);
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        chk("empty_play", 32'(busy), 0);

        for (int i = 0; i < 17; i++) begin
            rec(4'(i), 2'(i), 1'b1);
            if (i == 15) begin
                chk("full_flag", 32'(full), 1);
                chk("full_ready", 32'(rec_ready), 0);
            end
        end
        chk("full_count", 32'(count), 16);

`ifdef NOTE_SEQ_LOOP_PLAY_EN
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        rec(4'd3, 2'd1, 1'b1);
        rec(4'd8, 2'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            e.n   = m_mem[i % 2][3:0];
            e.o   = m_mem[i % 2][5:4];
            e.idx = 4'(i % 2);
            q_note.push_back(e);
            q_draw.push_back(mk_draw(i % 2, 3'b110));
        end
        @(negedge clk);
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serve(1, 1'b0);
            if (i < 5) begin
                tick();
                chk("loop_done", 32'(done), 32'(i % 2));
                chk("loop_note_valid", 32'(note_valid), 1);
            end
        end
        play_stop = 1'b1;
        @(negedge clk);
        play_stop = 1'b0;
        chk("loop_stop_busy", 32'(busy), 0);
`endif

        chk("draw_q_empty", 32'(q_draw.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
